// File: rtl/decoder_frame_feeder_if.sv
// Stream-side and decoder-side signals of the frame feeder.
// The master modport is the feeder's view; slave is the environment's view.
interface decoder_frame_feeder_if #(
  parameter int SYM_W          = 21,
  parameter int WORDS_PER_BEAT = 4
);
  localparam int DATA_W = SYM_W * WORDS_PER_BEAT;

  logic              sym_valid_i;
  logic [SYM_W-1:0]  sym_data_i;
  logic              sym_ready_o;
  logic              start_o;
  logic [DATA_W-1:0] data_o;
  logic              done_i;
  logic              busy_o;
  logic [15:0]       frames_o;

  modport master (
    input  sym_valid_i, sym_data_i, done_i,
    output sym_ready_o, start_o, data_o, busy_o, frames_o
  );

  modport slave (
    output sym_valid_i, sym_data_i, done_i,
    input  sym_ready_o, start_o, data_o, busy_o, frames_o
  );
endinterface

// File: rtl/decoder_frame_feeder.sv
// Collects symbol words into ping-pong frame banks and feeds each frame to the
// decoder as consecutive wide beats, waiting for done before the next frame.
module decoder_frame_feeder #(
  parameter int SYM_W          = 21,
  parameter int WORDS_PER_BEAT = 4,
  parameter int BEATS          = 4
) (
  input  logic                   clk_p_i,
  input  logic                   reset_n_i,
  decoder_frame_feeder_if.master bus
);
  localparam int DATA_W      = SYM_W * WORDS_PER_BEAT;
  localparam int FRAME_WORDS = BEATS * WORDS_PER_BEAT;
  localparam int IDX_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        full_reg, full_next;
  logic              wr_bank_reg;
  logic [IDX_W-1:0]  wr_idx_reg;
  logic              rd_bank_reg, rd_bank_next;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic [BEAT_W-1:0] beat_sel;
  logic              start_reg, start_next;
  logic              busy_reg, busy_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [DATA_W-1:0] beat_data;
  logic [15:0]       frames_reg;
  logic              sym_accept;
  logic              frame_filled;
  logic              frame_done;

  logic [SYM_W-1:0] bank_mem [2][FRAME_WORDS];

  // Ready depends only on registers so upstream never sees a comb loop.
  assign bus.sym_ready_o = ~full_reg[wr_bank_reg];
  assign sym_accept      = bus.sym_valid_i & ~full_reg[wr_bank_reg];
  assign frame_filled    = sym_accept & (wr_idx_reg == LAST_IDX);
  assign frame_done      = (state_reg == ST_WAIT) & bus.done_i;

  always_ff @(posedge clk_p_i) begin
    if (sym_accept) begin
      bank_mem[wr_bank_reg][wr_idx_reg] <= bus.sym_data_i;
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_bank_reg <= 1'b0;
      wr_idx_reg  <= '0;
    end else if (sym_accept) begin
      if (frame_filled) begin
        wr_idx_reg  <= '0;
        wr_bank_reg <= ~wr_bank_reg;
      end else begin
        wr_idx_reg  <= wr_idx_reg + IDX_W'(1);
      end
    end
  end

  // Fill and send never target the same bank, so set and clear can coexist.
  always_comb begin
    full_next = full_reg;
    if (frame_filled) full_next[wr_bank_reg] = 1'b1;
    if (frame_done)   full_next[rd_bank_reg] = 1'b0;
  end

  // Beat packing: word 4b lands in the least-significant lane.
  assign beat_sel = (state_reg == ST_SEND) ? beat_reg : '0;

  generate
    for (genvar gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_pack
      assign beat_data[gi*SYM_W +: SYM_W] =
        bank_mem[rd_bank_reg][IDX_W'(beat_sel) * IDX_W'(WORDS_PER_BEAT) + IDX_W'(gi)];
    end
  endgenerate

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= ST_IDLE;
      full_reg    <= 2'b00;
      rd_bank_reg <= 1'b0;
      beat_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      full_reg    <= full_next;
      rd_bank_reg <= rd_bank_next;
      beat_reg    <= beat_next;
    end
  end

  // beat_reg holds the index of the beat launched while in SEND; the IDLE
  // exit launches beat 0 itself so the first beat costs no extra cycle.
  always_comb begin
    state_next   = state_reg;
    beat_next    = beat_reg;
    rd_bank_next = rd_bank_reg;
    case (state_reg)
      ST_IDLE: begin
        if (full_reg[rd_bank_reg]) begin
          state_next = ST_SEND;
          beat_next  = BEAT_W'(1);
        end
      end
      ST_SEND: begin
        beat_next = beat_reg + BEAT_W'(1);
        if (beat_reg == LAST_BEAT) begin
          state_next = ST_WAIT;
          beat_next  = '0;
        end
      end
      ST_WAIT: begin
        if (bus.done_i) begin
          state_next   = ST_IDLE;
          rd_bank_next = ~rd_bank_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    start_next = 1'b0;
    data_next  = data_reg;
    busy_next  = (state_next != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (full_reg[rd_bank_reg]) begin
          start_next = 1'b1;
          data_next  = beat_data;
        end
      end
      ST_SEND: begin
        start_next = 1'b1;
        data_next  = beat_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      start_reg <= 1'b0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      start_reg <= start_next;
      data_reg  <= data_next;
      busy_reg  <= busy_next;
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frames_reg <= 16'd0;
    end else if (frame_done) begin
      frames_reg <= frames_reg + 16'd1;
    end
  end

  assign bus.start_o  = start_reg;
  assign bus.data_o   = data_reg;
  assign bus.busy_o   = busy_reg;
  assign bus.frames_o = frames_reg;
endmodule
